// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// Requests complete on req&&ready; responses return in request order, one per rvalid.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, in-order imem requests, PC-tag + response FIFOs, IF/ID register.
// A response reaches IF/ID at the edge it arrives when the FIFO is empty; requests stop once outstanding+buffered hits BUF_DEPTH.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               pcsrc_e,
    input  logic [31:0]        pc_target_e,
    fetch_stage_if.master      imem,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc_plus4_d,
    output logic               valid_d
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rsp_t;

    logic [31:0]   pc_f_q, pc_f_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0]   ifid_instr_q, ifid_instr_d;
    logic [31:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]   ifid_pc4_q, ifid_pc4_d;
    logic          ifid_vld_q, ifid_vld_d;

    logic [31:0]   tag_mem_q [BUF_DEPTH];
    logic [31:0]   tag_mem_d [BUF_DEPTH];
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d;

    rsp_t          rsp_mem_q [BUF_DEPTH];
    rsp_t          rsp_mem_d [BUF_DEPTH];
    logic [AW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic [CW:0]   in_flight;
    logic          req;
    logic          accept;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          rsp_empty;
    logic          head_vld;
    rsp_t          head;
    rsp_t          incoming;
    logic          take;
    logic          rsp_push;
    logic          rsp_pop;
    logic          tag_pop;
    logic          unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^pc_target_e[1:0];

    // Buffered words count against the window so every accepted request has a FIFO slot waiting.
    assign in_flight = {1'b0, outstanding_q} + {1'b0, rsp_cnt_q};
    assign req       = !rst && !stall_f && !pcsrc_e && (in_flight < {1'b0, DEPTH_C});
    assign accept    = req && imem.imem_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_f_q;

    assign rsp_keep  = imem.imem_rvalid && (discard_q == '0);
    assign rsp_drop  = imem.imem_rvalid && (discard_q != '0);
    assign tag_pop   = rsp_keep;
    assign rsp_empty = (rsp_cnt_q == '0);
    assign incoming  = {tag_mem_q[tag_rd_q], imem.imem_rdata};
    assign head_vld  = !rsp_empty || rsp_keep;
    assign head      = rsp_empty ? incoming : rsp_mem_q[rsp_rd_q];
    assign rsp_push  = rsp_keep && !(rsp_empty && take);
    assign rsp_pop   = take && !rsp_empty;

    always_comb begin
        pc_f_d        = pc_f_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem.imem_rvalid);
        discard_d     = discard_q;
        if (pcsrc_e) begin
            pc_f_d    = {pc_target_e[31:2], 2'b00};
            discard_d = outstanding_q - CW'(imem.imem_rvalid);
        end else begin
            if (accept) begin
                pc_f_d = pc_f_q + 32'd4;
            end
            if (rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        take         = 1'b0;
        if (pcsrc_e) begin
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (stall_d) begin
            ifid_vld_d   = ifid_vld_q;
        end else if (flush_d) begin
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (head_vld) begin
            take         = 1'b1;
            ifid_vld_d   = 1'b1;
            ifid_instr_d = head.instr;
            ifid_pc_d    = head.pc;
            ifid_pc4_d   = head.pc + 32'd4;
        end else begin
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        rsp_mem_d = rsp_mem_q;
        rsp_wr_d  = rsp_wr_q;
        rsp_rd_d  = rsp_rd_q;
        rsp_cnt_d = rsp_cnt_q;
        if (pcsrc_e) begin
            tag_wr_d  = '0;
            tag_rd_d  = '0;
            tag_cnt_d = '0;
            rsp_wr_d  = '0;
            rsp_rd_d  = '0;
            rsp_cnt_d = '0;
        end else begin
            if (accept) begin
                tag_mem_d[tag_wr_q] = pc_f_q;
                tag_wr_d            = tag_wr_q + AW'(1);
            end
            if (tag_pop) begin
                tag_rd_d = tag_rd_q + AW'(1);
            end
            tag_cnt_d = tag_cnt_q + CW'(accept) - CW'(tag_pop);
            if (rsp_push) begin
                rsp_mem_d[rsp_wr_q] = incoming;
                rsp_wr_d            = rsp_wr_q + AW'(1);
            end
            if (rsp_pop) begin
                rsp_rd_d = rsp_rd_q + AW'(1);
            end
            rsp_cnt_d = rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q        <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= '0;
            ifid_pc4_q    <= '0;
            ifid_vld_q    <= 1'b0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_cnt_q     <= '0;
            rsp_wr_q      <= '0;
            rsp_rd_q      <= '0;
            rsp_cnt_q     <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_vld_q    <= ifid_vld_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_cnt_q     <= tag_cnt_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_cnt_q     <= rsp_cnt_d;
        end
        tag_mem_q <= tag_mem_d;
        rsp_mem_q <= rsp_mem_d;
    end

    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_vld_q;

    a_tag_ovf: assert property (@(posedge clk) disable iff (rst)
        !(accept && !tag_pop && tag_cnt_q == DEPTH_C));
    a_tag_unf: assert property (@(posedge clk) disable iff (rst)
        !(tag_pop && tag_cnt_q == '0));
    a_rsp_ovf: assert property (@(posedge clk) disable iff (rst)
        !(rsp_push && !rsp_pop && rsp_cnt_q == DEPTH_C));
    a_rsp_unf: assert property (@(posedge clk) disable iff (rst)
        !(rsp_pop && rsp_cnt_q == '0));
    a_discard: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch-stage bench: memory model with per-request latency and a queue-based program-order reference.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    fetch_stage_if imem();

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(BUF_DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pc_target_e(pc_target_e),
        .imem       (imem),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          gen;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] buf_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          gen = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          armed = 1'b0;
    logic [31:0] exp_pc, exp_instr, exp_pcd, exp_pc4;
    logic        exp_vld;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A3C_0000;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                        input logic pe, input logic [31:0] tgt, input logic rdy);
        mreq_t       rsp;
        logic        rv;
        logic        exp_req;
        int          inflight;
        int          d_cyc;
        logic [31:0] a;
        rst         = r;
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pcsrc_e     = pe;
        pc_target_e = tgt;
        imem.imem_ready = rdy;
        rv  = 1'b0;
        rsp = '{addr: 32'h0, due: 0, gen: 0};
        if (r) begin
            mq.delete();
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            rsp = mq.pop_front();
            rv  = 1'b1;
        end
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? mem_word(rsp.addr) : $urandom();

        @(negedge clk);
        if (armed) begin
            chk_eq("valid_d", valid_d, exp_vld);
            chk_eq("instr_d", instr_d, exp_instr);
            chk_eq("pc_d", pc_d, exp_pcd);
            chk_eq("pc_plus4_d", pc_plus4_d, exp_pc4);
        end
        inflight = mq.size() + int'(rv) + buf_q.size();
        exp_req  = !r && !sf && !pe && (inflight < BUF_DEPTH);
        chk_eq("imem_req", imem.imem_req, exp_req);
        if (exp_req) chk_eq("imem_addr", imem.imem_addr, exp_pc);

        if (r) begin
            buf_q.delete();
            exp_pc    = RESET_PC;
            exp_vld   = 1'b0;
            exp_instr = NOP;
            exp_pcd   = 32'h0;
            exp_pc4   = 32'h0;
            last_due  = cyc;
            armed     = 1'b1;
        end else begin
            if (exp_req && rdy) begin
                d_cyc = cyc + $urandom_range(lat_hi, lat_lo);
                if (d_cyc <= last_due) d_cyc = last_due + 1;
                last_due = d_cyc;
                mq.push_back('{addr: exp_pc, due: d_cyc, gen: gen});
                exp_pc = exp_pc + 32'd4;
            end
            if (rv && rsp.gen == gen) buf_q.push_back(rsp.addr);
            if (pe) begin
                buf_q.delete();
                gen++;
                exp_pc    = {tgt[31:2], 2'b00};
                exp_vld   = 1'b0;
                exp_instr = NOP;
            end else if (sd) begin
                exp_vld = exp_vld;
            end else if (fl || buf_q.size() == 0) begin
                exp_vld   = 1'b0;
                exp_instr = NOP;
            end else begin
                a         = buf_q.pop_front();
                exp_vld   = 1'b1;
                exp_instr = mem_word(a);
                exp_pcd   = a;
                exp_pc4   = a + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic found;
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pcsrc_e = 1'b0;
        pc_target_e = 32'h0;
        imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // back-to-back fetch at L=1, then a one-cycle load-use hold while pc_d is 0x8
        run(4);
        chk_eq("ld_use_pc", pc_d, 32'h8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("ld_use_hold", pc_d, 32'h8);
        run(4);

        lat_lo = 2; lat_hi = 2;
        run(4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
        chk_eq("redir_bubble", valid_d, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (valid_d) begin
                found = 1'b1;
                chk_eq("redir_first_pc", pc_d, 32'h100);
            end
        end
        chk_eq("redir_seen", found, 1'b1);

        lat_lo = 1; lat_hi = 1;
        run(3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        run(6);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        run(8);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1);
        run(6);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_eq("rst_valid", valid_d, 1'b0);
        chk_eq("rst_instr", instr_d, NOP);
        run(4);

        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199, 0) == 0,
                 $urandom_range(9, 0) < 2,
                 $urandom_range(4, 0) == 0,
                 $urandom_range(19, 0) == 0,
                 $urandom_range(19, 0) == 0,
                 $urandom() & 32'h0000_FFFF,
                 $urandom_range(9, 0) < 7);
        end
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
